// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 encryption engine, one block in flight.
// Each round takes K = 16/SUB_PER_CYCLE cycles: every cycle substitutes one
// group of SUB_PER_CYCLE state bytes in place. The last phase of a round also
// does ShiftRows, MixColumns (skipped in the final round) and AddRoundKey.
// The next round key is expanded on the fly from the current one.
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      plaintext/key handshake (key sampled on accept)
//   plain_text, key        128-bit input block and cipher key
//   out_valid/out_ready    ciphertext handshake, data held under backpressure
//   cipher_text            registered 128-bit result
//   busy                   a block is being processed or waiting to be taken
module aes_iter_core #(
  parameter int NR            = 10,
  parameter int SUB_PER_CYCLE = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain_text,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher_text,
  output logic         busy
);

  localparam int K  = 16 / SUB_PER_CYCLE;
  localparam int PW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ m;
      m = xtime(m);
    end
    return p;
  endfunction

  // S-box computed arithmetically: inverse as a^254 (0 maps to 0), then the
  // affine transform written as XOR of left rotations plus 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] inv;
    t   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [1:0]    fsm_reg;
  logic [127:0]  state_reg;
  logic [127:0]  rkey_reg;
  logic [127:0]  cipher_reg;
  logic [3:0]    round_reg;
  logic [PW-1:0] phase_reg;
  logic [7:0]    rcon_reg;

  logic [7:0]    st_b  [16];
  logic [7:0]    sub_b [16];
  logic [7:0]    sr_b  [16];
  logic [7:0]    mc_b  [16];
  logic [3:0]    sub_idx [SUB_PER_CYCLE];
  logic [7:0]    sub_out [SUB_PER_CYCLE];
  logic [127:0]  sub_vec;
  logic [127:0]  next_state;
  logic [127:0]  next_rkey;
  logic [31:0]   rot_w;
  logic [31:0]   ks_sub;
  logic [31:0]   nw0, nw1, nw2, nw3;
  logic          last_round;
  logic          last_phase;

  assign last_round = (round_reg == 4'(NR));
  assign last_phase = (phase_reg == PW'(K - 1));

  // Byte b0 is the most significant byte of the state.
  for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
    assign st_b[gi] = state_reg[127 - 8*gi -: 8];
  end

  // Only SUB_PER_CYCLE S-boxes exist; the current phase selects which bytes.
  for (genvar gi = 0; gi < SUB_PER_CYCLE; gi++) begin : g_sub
    assign sub_idx[gi] = 4'(int'(phase_reg) * SUB_PER_CYCLE + gi);
    assign sub_out[gi] = sbox(st_b[sub_idx[gi]]);
  end

  always_comb begin
    sub_b = st_b;
    for (int j = 0; j < SUB_PER_CYCLE; j++) begin
      sub_b[sub_idx[j]] = sub_out[j];
    end
  end

  // ShiftRows: row r rotates left by r columns; byte (r,c) sits at r+4c.
  for (genvar gi = 0; gi < 16; gi++) begin : g_shift
    localparam int R = gi % 4;
    localparam int C = gi / 4;
    assign sr_b[gi] = sub_b[R + 4*((C + R) % 4)];
    assign sub_vec[127 - 8*gi -: 8] = sub_b[gi];
  end

  // MixColumns with the {02,03,01,01} circulant matrix; 3*a = xtime(a)^a.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mc_b[4*gi+0] = xtime(sr_b[4*gi+0]) ^ xtime(sr_b[4*gi+1]) ^ sr_b[4*gi+1] ^ sr_b[4*gi+2] ^ sr_b[4*gi+3];
    assign mc_b[4*gi+1] = sr_b[4*gi+0] ^ xtime(sr_b[4*gi+1]) ^ xtime(sr_b[4*gi+2]) ^ sr_b[4*gi+2] ^ sr_b[4*gi+3];
    assign mc_b[4*gi+2] = sr_b[4*gi+0] ^ sr_b[4*gi+1] ^ xtime(sr_b[4*gi+2]) ^ xtime(sr_b[4*gi+3]) ^ sr_b[4*gi+3];
    assign mc_b[4*gi+3] = xtime(sr_b[4*gi+0]) ^ sr_b[4*gi+0] ^ sr_b[4*gi+1] ^ sr_b[4*gi+2] ^ xtime(sr_b[4*gi+3]);
  end

  // Key schedule: four dedicated S-boxes on RotWord(w3).
  assign rot_w = {rkey_reg[23:0], rkey_reg[31:24]};
  for (genvar gi = 0; gi < 4; gi++) begin : g_ks
    assign ks_sub[31 - 8*gi -: 8] = sbox(rot_w[31 - 8*gi -: 8]);
  end
  assign nw0       = rkey_reg[127:96] ^ ks_sub ^ {rcon_reg, 24'h0};
  assign nw1       = rkey_reg[95:64]  ^ nw0;
  assign nw2       = rkey_reg[63:32]  ^ nw1;
  assign nw3       = rkey_reg[31:0]   ^ nw2;
  assign next_rkey = {nw0, nw1, nw2, nw3};

  for (genvar gi = 0; gi < 16; gi++) begin : g_ark
    assign next_state[127 - 8*gi -: 8] = (last_round ? sr_b[gi] : mc_b[gi]) ^ next_rkey[127 - 8*gi -: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg    <= IDLE;
      state_reg  <= '0;
      rkey_reg   <= '0;
      cipher_reg <= '0;
      round_reg  <= '0;
      phase_reg  <= '0;
      rcon_reg   <= 8'h01;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg <= plain_text ^ key;
            rkey_reg  <= key;
            round_reg <= 4'd1;
            phase_reg <= '0;
            rcon_reg  <= 8'h01;
            fsm_reg   <= RUN;
          end
        end
        RUN: begin
          if (!last_phase) begin
            state_reg <= sub_vec;
            phase_reg <= phase_reg + 1'b1;
          end else begin
            state_reg <= next_state;
            rkey_reg  <= next_rkey;
            rcon_reg  <= xtime(rcon_reg);
            if (last_round) begin
              cipher_reg <= next_state;
              fsm_reg    <= DONE;
            end else begin
              round_reg <= round_reg + 4'd1;
              phase_reg <= '0;
            end
          end
        end
        DONE: begin
          if (out_ready) fsm_reg <= IDLE;
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign in_ready    = (fsm_reg == IDLE);
  assign out_valid   = (fsm_reg == DONE);
  assign busy        = (fsm_reg != IDLE);
  assign cipher_text = cipher_reg;

endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: three core configurations (full AES-128 one round per
// cycle, full AES-128 four bytes per cycle, four-round eight bytes per cycle)
// driven with known-answer and random blocks. Expected ciphertexts come from
// FIPS-197 vectors or from a table-driven AES model; a monitor pops them when
// the core presents output and also checks latency and handshake behaviour.
module tb_aes_iter_core;

  localparam int NDUT = 3;
  localparam int NR_T  [NDUT] = '{10, 10, 4};
  localparam int SPC_T [NDUT] = '{16, 4, 8};
  localparam int LAT_T [NDUT] = '{10, 40, 8};

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NDUT-1:0] in_valid = '0;
  logic [NDUT-1:0] in_ready;
  logic [NDUT-1:0] out_valid;
  logic [NDUT-1:0] out_ready = '0;
  logic [NDUT-1:0] busy;
  logic [127:0]    plain_text  [NDUT];
  logic [127:0]    key_in      [NDUT];
  logic [127:0]    cipher_text [NDUT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    aes_iter_core #(.NR(NR_T[gi]), .SUB_PER_CYCLE(SPC_T[gi])) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid[gi]),
      .in_ready    (in_ready[gi]),
      .plain_text  (plain_text[gi]),
      .key         (key_in[gi]),
      .out_valid   (out_valid[gi]),
      .out_ready   (out_ready[gi]),
      .cipher_text (cipher_text[gi]),
      .busy        (busy[gi])
    );
  end

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Walks the multiplicative group with generator 3, pairing each element
  // with its inverse, and applies the affine map.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k, input int nr);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[row + 4*col] = s[row + 4*((col + row) % 4)];
      if (r < nr) begin
        for (int col = 0; col < 4; col++) begin
          a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
          s[4*col]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          s[4*col+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- scoreboard state ----------------
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [127:0]    exp_ct  [NDUT][16];
  int              exp_due [NDUT][16];
  int              exp_gap [NDUT][16];
  int              wr_p [NDUT] = '{0, 0, 0};
  int              rd_p [NDUT] = '{0, 0, 0};
  int              last_rise [NDUT] = '{0, 0, 0};
  logic [NDUT-1:0] ov_prev = '0;
  logic [NDUT-1:0] rdy_chk = '0;
  logic [NDUT-1:0] ign_chk = '0;
  logic [NDUT-1:0] or_force = '1;
  bit              bp_mode = 1'b0;
  int              to_posted = 0;
  int              to_seen = 0;
  int              rst_posted = 0;
  int              rst_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready changes just after the edge so it is stable when sampled.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NDUT; i++)
      out_ready[i] = bp_mode ? 1'($urandom_range(0, 1)) : or_force[i];
  end

  task automatic chk(input string name, input int i, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, required %0h", name, i, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int slot;
    while (to_seen < to_posted) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: bounded wait expired near cycle %0d", cyc);
      to_seen++;
    end
    if (rst_seen < rst_posted) begin
      rst_seen = rst_posted;
      for (int i = 0; i < NDUT; i++) begin
        chk("reset_in_ready",    i, 128'(in_ready[i]),  128'd1);
        chk("reset_out_valid",   i, 128'(out_valid[i]), 128'd0);
        chk("reset_busy",        i, 128'(busy[i]),      128'd0);
        chk("reset_cipher_text", i, cipher_text[i],     128'd0);
        rd_p[i]    = wr_p[i];
        rdy_chk[i] = 1'b0;
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      if (out_valid[i]) begin
        if (rd_p[i] == wr_p[i]) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output dut%0d cycle %0d: got %0h, required no output", i, cyc, cipher_text[i]);
        end else begin
          slot = rd_p[i] % 16;
          if (!ov_prev[i]) begin
            chk("latency", i, 128'(cyc), 128'(exp_due[i][slot]));
            if (exp_gap[i][slot] != 0)
              chk("b2b_gap", i, 128'(cyc - last_rise[i]), 128'(exp_gap[i][slot]));
            last_rise[i] = cyc;
          end
          chk("cipher_text", i, cipher_text[i], exp_ct[i][slot]);
          chk("in_ready_low_done", i, 128'(in_ready[i]), 128'd0);
          if (out_ready[i]) begin
            $display("dut%0d block %0d taken at cycle %0d ct=%h", i, rd_p[i], cyc, cipher_text[i]);
            rd_p[i]++;
            rdy_chk[i] = 1'b1;
          end
        end
      end else if (rdy_chk[i]) begin
        chk("in_ready_after_out", i, 128'(in_ready[i]), 128'd1);
        rdy_chk[i] = 1'b0;
      end
      if (ign_chk[i]) begin
        chk("in_ready_low_run", i, 128'(in_ready[i]), 128'd0);
        chk("busy_run", i, 128'(busy[i]), 128'd1);
      end
      ov_prev[i] = out_valid[i];
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; the block is accepted on the next edge with in_ready.
  task automatic send(input int i, input logic [127:0] pt, input logic [127:0] k,
                      input logic [127:0] exp, input int gap);
    int n;
    int slot;
    n = 0;
    plain_text[i] = pt;
    key_in[i]     = k;
    in_valid[i]   = 1'b1;
    while (!in_ready[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[i]) begin
      to_posted++;
      in_valid[i] = 1'b0;
      return;
    end
    slot = wr_p[i] % 16;
    exp_ct[i][slot]  = exp;
    exp_due[i][slot] = cyc + 1 + LAT_T[i];
    exp_gap[i][slot] = gap;
    wr_p[i]++;
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (rd_p[i] != wr_p[i] && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (rd_p[i] != wr_p[i]) to_posted++;
  endtask

  task automatic wait_ov(input int i);
    int n;
    n = 0;
    while (!out_valid[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[i]) to_posted++;
  endtask

  initial begin
    logic [127:0] pt, k;
    build_sbox();
    for (int i = 0; i < NDUT; i++) begin
      plain_text[i] = '0;
      key_in[i]     = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rst_posted++;
    repeat (2) @(negedge clk);

    // FIPS-197 C.1 and App.B known answers
    send(0, C1_PT, C1_KEY, C1_CT, 0);
    drain(0);
    send(1, B_PT, B_KEY, B_CT, 0);
    drain(1);

    // backpressure: out_ready low for 7 cycles of out_valid
    or_force[0] = 1'b0;
    @(negedge clk);
    send(0, C1_PT, C1_KEY, C1_CT, 0);
    wait_ov(0);
    repeat (6) @(negedge clk);
    or_force[0] = 1'b1;
    drain(0);

    // in_valid pulse with another block while running must be ignored
    send(0, C1_PT, C1_KEY, C1_CT, 0);
    repeat (2) @(negedge clk);
    plain_text[0] = B_PT;
    in_valid[0]   = 1'b1;
    ign_chk[0]    = 1'b1;
    repeat (2) @(negedge clk);
    in_valid[0] = 1'b0;
    ign_chk[0]  = 1'b0;
    drain(0);
    repeat (15) @(negedge clk);

    // reset on the fifth RUN cycle discards the block
    send(0, C1_PT, C1_KEY, C1_CT, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rst_posted++;
    repeat (2) @(negedge clk);
    send(0, C1_PT, C1_KEY, C1_CT, 0);
    drain(0);

    // back-to-back App.B then C.1, results 12 cycles apart
    send(0, B_PT, B_KEY, B_CT, 0);
    send(0, C1_PT, C1_KEY, C1_CT, 12);
    drain(0);

    // random blocks with random backpressure on every configuration
    bp_mode = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      for (int b = 0; b < 6; b++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        k  = {$urandom, $urandom, $urandom, $urandom};
        send(i, pt, k, aes_ref(pt, k, NR_T[i]), 0);
      end
      drain(i);
    end
    bp_mode = 1'b0;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
